// File: rtl/avr_uart_tx_pkg.sv
// Shared definitions for the AVR-facing UART transmitter: FSM encoding and defaults.
package avr_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DEFAULT_CLK_PER_BIT = 100;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

endpackage

// File: rtl/avr_uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter; one extra pointer bit separates full from empty.
module avr_uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/avr_uart_tx.sv
// UART transmitter towards an AVR: input FIFO, block synchronizer, 8N1 frame FSM and shifter.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte and block_s low
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (high); chains straight into ST_START if another byte may go
module avr_uart_tx
    import avr_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       block,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    tx_state_e   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        tx_nxt;
    logic        busy_nxt;
    logic        block_m, block_s;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        bit_done, can_load;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    avr_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (cnt == CNT_LAST);
    assign can_load = !fifo_empty && !block_s;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_done ? '0 : cnt + CNT_ONE;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        fifo_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (can_load) begin
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_dout;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (can_load) begin
                        fifo_pop  = 1'b1;
                        shreg_nxt = fifo_dout;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // The line follows the state one cycle later, which keeps tx a plain flop.
    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shreg[0];
            default:  tx_nxt = 1'b1;
        endcase
        busy_nxt = (state != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            block_m <= 1'b0;
            block_s <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            block_m <= block;
            block_s <= block_m;
        end
    end

endmodule
